// File: rtl/dice_input_ctrl.sv
// Debounces the cycle and roll push-buttons and keeps the current die face (1..6).
// Optional feature: define DICE_RANDOM_EN so that a roll press loads the face from a free-running counter.
module dice_input_ctrl #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic       clk,
    input  logic       rst_full,
    input  logic       btn_cycle_raw,
    input  logic       btn_roll_raw,
    output logic       cycle_pulse,
    output logic       roll_pulse,
    output logic [2:0] dice_value,
    output logic [1:0] btn_state
);

    localparam int          BTN_CYCLE = 0;
    localparam int          BTN_ROLL  = 1;
    localparam logic [19:0] CNT_LAST  = 20'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } btn_fsm_t;

    logic [1:0] raw;
    logic [1:0] sync_a;
    logic [1:0] sync_b;
    logic [1:0] press;

    assign raw = {btn_roll_raw, btn_cycle_raw};

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst_full) begin
            sync_a <= '0;
            sync_b <= '0;
        end else begin
            sync_a <= raw;
            sync_b <= sync_a;
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_btn
        btn_fsm_t    state;
        logic [19:0] cnt;
        logic        held;

        // The press event is the cycle the counter has seen the last stable sample.
        assign press[b]     = (state == PRESS_WAIT) && sync_b[b] && (cnt == CNT_LAST);
        assign btn_state[b] = held;

        always_ff @(posedge clk) begin
            if (rst_full) begin
                state <= IDLE;
                cnt   <= '0;
                held  <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (sync_b[b]) begin
                            state <= PRESS_WAIT;
                            cnt   <= '0;
                        end
                    end
                    PRESS_WAIT: begin
                        if (!sync_b[b]) begin
                            state <= IDLE;
                        end else if (cnt == CNT_LAST) begin
                            state <= HELD;
                            held  <= 1'b1;
                        end else begin
                            cnt <= cnt + 20'd1;
                        end
                    end
                    HELD: begin
                        if (!sync_b[b]) begin
                            state <= RELEASE_WAIT;
                            cnt   <= '0;
                        end
                    end
                    RELEASE_WAIT: begin
                        if (sync_b[b]) begin
                            state <= HELD;
                        end else if (cnt == CNT_LAST) begin
                            state <= IDLE;
                            held  <= 1'b0;
                        end else begin
                            cnt <= cnt + 20'd1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        held  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Illegal encodings fold back to 1 so the face can never settle on 0 or 7.
    function automatic logic [2:0] next_face(input logic [2:0] v);
        return ((v >= 3'd6) || (v == 3'd0)) ? 3'd1 : v + 3'd1;
    endfunction

`ifdef DICE_RANDOM_EN
    logic [2:0] face_cnt;

    always_ff @(posedge clk) begin
        if (rst_full) begin
            face_cnt <= 3'd1;
        end else begin
            face_cnt <= next_face(face_cnt);
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst_full) begin
            cycle_pulse <= 1'b0;
            roll_pulse  <= 1'b0;
            dice_value  <= 3'd1;
        end else begin
            cycle_pulse <= press[BTN_CYCLE];
            roll_pulse  <= press[BTN_ROLL];
`ifdef DICE_RANDOM_EN
            if (press[BTN_ROLL]) begin
                dice_value <= face_cnt;
            end else if (press[BTN_CYCLE]) begin
                dice_value <= next_face(dice_value);
            end
`else
            if (press[BTN_CYCLE]) begin
                dice_value <= next_face(dice_value);
            end
`endif
        end
    end

endmodule

// File: tb/tb_dice_input_ctrl.sv
// Randomized and directed bench for dice_input_ctrl against a run-length behavioural model.
// The model honours DICE_RANDOM_EN when the bench is built with the same macro.
module tb_dice_input_ctrl;

    localparam int D = 8;

    logic       clk = 1'b0;
    logic       rst_full = 1'b1;
    logic       btn_cycle_raw = 1'b0;
    logic       btn_roll_raw = 1'b0;
    logic       cycle_pulse;
    logic       roll_pulse;
    logic [2:0] dice_value;
    logic [1:0] btn_state;

    int total = 0;
    int bad   = 0;

    dice_input_ctrl #(.DEBOUNCE_CYCLES(D)) dut (
        .clk          (clk),
        .rst_full     (rst_full),
        .btn_cycle_raw(btn_cycle_raw),
        .btn_roll_raw (btn_roll_raw),
        .cycle_pulse  (cycle_pulse),
        .roll_pulse   (roll_pulse),
        .dice_value   (dice_value),
        .btn_state    (btn_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Behavioural model: a button's debounced level flips once the synced input
    // has disagreed with it for D+1 consecutive cycles; a 0->1 flip is a press.
    bit d1 [2];
    bit d2 [2];
    bit lvl [2];
    int run [2];
    int m_dice;
    int since_rst;
    bit exp_cp, exp_rp;

    int tick_no = 0;
    int n_cycle = 0;
    int n_roll = 0;
    int last_roll_tick = 0;
    int last_cycle_tick = 0;

    task automatic model_step(input bit c, input bit r, input bit rst);
        bit raw [2];
        bit ev [2];
        bit s;
        int face;
        raw[0] = c;
        raw[1] = r;
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                d1[b] = 0; d2[b] = 0; lvl[b] = 0; run[b] = 0;
            end
            m_dice = 1;
            since_rst = 0;
            exp_cp = 0;
            exp_rp = 0;
        end else begin
            for (int b = 0; b < 2; b++) begin
                s = d2[b];
                d2[b] = d1[b];
                d1[b] = raw[b];
                ev[b] = 0;
                if (s == lvl[b]) begin
                    run[b] = 0;
                end else begin
                    run[b]++;
                    if (run[b] == D + 1) begin
                        lvl[b] = s;
                        run[b] = 0;
                        ev[b] = s;
                    end
                end
            end
            face = (since_rst % 6) + 1;
            since_rst++;
`ifdef DICE_RANDOM_EN
            if (ev[1]) m_dice = face;
            else if (ev[0]) m_dice = (m_dice % 6) + 1;
`else
            if (ev[0]) m_dice = (m_dice % 6) + 1;
`endif
            exp_cp = ev[0];
            exp_rp = ev[1];
        end
    endtask

    task automatic tick(input bit c, input bit r, input bit rst);
        btn_cycle_raw = c;
        btn_roll_raw  = r;
        rst_full      = rst;
        @(posedge clk);
        model_step(c, r, rst);
        #1;
        tick_no++;
        check("cycle_pulse", cycle_pulse, exp_cp);
        check("roll_pulse", roll_pulse, exp_rp);
        check("dice_value", dice_value, m_dice);
        check("btn_state", btn_state, {lvl[1], lvl[0]});
        check("dice_range", (dice_value >= 3'd1 && dice_value <= 3'd6), 1);
        if (cycle_pulse === 1'b1) begin n_cycle++; last_cycle_tick = tick_no; end
        if (roll_pulse === 1'b1) begin n_roll++; last_roll_tick = tick_no; end
    endtask

    task automatic hold(input bit c, input bit r, input int n);
        for (int i = 0; i < n; i++) tick(c, r, 1'b0);
    endtask

    int face_seq [6] = '{2, 3, 4, 5, 6, 1};
    int base;
    int hold_start;
    int rem [2];
    bit lv [2];

    initial begin
        // Reset and the first idle cycle after release.
        hold(1'b0, 1'b0, 0);
        tick(1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b1);
        check("reset_dice", dice_value, 1);
        check("reset_btn_state", btn_state, 0);
        tick(1'b0, 1'b0, 1'b0);
        check("first_cycle_no_pulse", {roll_pulse, cycle_pulse}, 0);

        // Six clean cycle presses walk the face around 2..6,1.
        for (int i = 0; i < 6; i++) begin
            base = n_cycle;
            hold(1'b1, 1'b0, D + 6);
            hold(1'b0, 1'b0, D + 6);
            check("six_press_count", n_cycle - base, 1);
            check("six_press_face", dice_value, face_seq[i]);
        end

        // Bouncing roll button, then a stable hold.
        base = n_roll;
        for (int i = 0; i < 40; i++) tick(1'b0, ((i / 3) % 2) == 0, 1'b0);
        check("bounce_no_pulse", n_roll - base, 0);
        hold_start = tick_no + 1;
        hold(1'b0, 1'b1, 30);
        check("bounce_roll_count", n_roll - base, 1);
        check("bounce_roll_latency", last_roll_tick - hold_start + 1, 2 + D + 1);
        hold(1'b0, 1'b0, D + 6);

        // Long hold, then a short release glitch.
        base = n_cycle;
        hold(1'b1, 1'b0, 100);
        check("long_hold_count", n_cycle - base, 1);
        hold(1'b0, 1'b0, 3);
        hold(1'b1, 1'b0, 30);
        check("glitch_no_pulse", n_cycle - base, 1);
        hold(1'b0, 1'b0, D + 6);

        // Bring the face to 4, then reset in the middle of a press.
        for (int i = 0; i < 6 && m_dice != 4; i++) begin
            hold(1'b1, 1'b0, D + 6);
            hold(1'b0, 1'b0, D + 6);
        end
        check("pre_reset_face", dice_value, 4);
        base = n_cycle;
        hold(1'b1, 1'b0, 5);
        tick(1'b1, 1'b0, 1'b1);
        check("midpress_reset_dice", dice_value, 1);
        check("midpress_reset_state", btn_state, 0);
        hold_start = tick_no + 1;
        hold(1'b1, 1'b0, 20);
        check("midpress_one_pulse", n_cycle - base, 1);
        check("midpress_full_debounce", last_cycle_tick - hold_start + 1, 2 + D + 1);
        hold(1'b0, 1'b0, D + 6);

        // Both buttons accepted in the same cycle.
        base = n_cycle;
        hold(1'b1, 1'b1, D + 6);
        check("both_same_tick", last_cycle_tick, last_roll_tick);
        check("both_cycle_count", n_cycle - base, 1);
        hold(1'b0, 1'b0, D + 6);

        // Random stimulus with occasional resets.
        rem[0] = 0;
        rem[1] = 0;
        for (int i = 0; i < 3000; i++) begin
            for (int b = 0; b < 2; b++) begin
                if (rem[b] == 0) begin
                    lv[b]  = 1'($urandom_range(0, 1));
                    rem[b] = $urandom_range(1, 2 * D + 4);
                end
                rem[b]--;
            end
            tick(lv[0], lv[1], $urandom_range(0, 499) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
